// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and frame constants
package uart_pkg;
   localparam int CLKS_PER_BIT_DEF = 87;
   localparam int DATA_W = 8;
   localparam int IDX_W = $clog2(DATA_W);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CLEANUP} state_e;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts 0..CLKS_PER_BIT-1 and ticks bit_end on the last cycle of each bit
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_restart,
   output logic o_bit_end
);
   localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   logic [W-1:0] cnt_q, cnt_d;
   always_comb begin
      o_bit_end = cnt_q == W'(CLKS_PER_BIT - 1);
      cnt_d = (i_restart || o_bit_end) ? '0 : cnt_q + W'(1);
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8-N-1 UART transmitter with registered outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic              i_Clock,
   input  logic              i_Rst_n,
   input  logic              i_Tx_DV,
   input  logic [DATA_W-1:0] i_Tx_Byte,
   output logic              o_Tx_Active,
   output logic              o_Tx_Serial,
   output logic              o_Tx_Done
);
`ifdef UART_TX_PARITY_EN
   localparam state_e AFTER_DATA = PARITY;
`else
   localparam state_e AFTER_DATA = STOP;
`endif
   state_e state_q, state_d;
   logic [DATA_W-1:0] byte_q, byte_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic serial_q, serial_d, active_q, active_d, done_q, done_d;
   logic bit_end;
   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .i_clk    (i_Clock),
      .i_rst_n  (i_Rst_n),
      .i_restart(state_q == IDLE || state_q == CLEANUP),
      .o_bit_end(bit_end)
   );
   always_comb begin
      state_d = state_q;
      byte_d = byte_q;
      idx_d = idx_q;
      case (state_q)
         IDLE: if (i_Tx_DV) begin
            state_d = START;
            byte_d = i_Tx_Byte;
            idx_d = '0;
         end
         START: if (bit_end) state_d = DATA;
         DATA: if (bit_end) begin
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(DATA_W - 1)) state_d = AFTER_DATA;
         end
         PARITY: if (bit_end) state_d = STOP;
         STOP: if (bit_end) state_d = CLEANUP;
         CLEANUP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // outputs follow the next state so they are registered yet aligned with it
      serial_d = !((state_d == START) || (state_d == DATA && !byte_d[idx_d]) ||
                   (state_d == PARITY && !(^byte_d)));
      active_d = state_d inside {START, DATA, PARITY, STOP};
      done_d = state_d == CLEANUP;
   end
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q <= IDLE;
         byte_q <= '0;
         idx_q <= '0;
         serial_q <= 1'b1;
         active_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         byte_q <= byte_d;
         idx_q <= idx_d;
         serial_q <= serial_d;
         active_q <= active_d;
         done_q <= done_d;
      end
   end
   assign o_Tx_Serial = serial_q;
   assign o_Tx_Active = active_q;
   assign o_Tx_Done = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx in its default 8-N-1 build
module tb_uart_tx;
   localparam int CPB = 87;
   localparam int FB = 10 * CPB;
   localparam int L = FB + 2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic dv = 1'b0;
   logic [7:0] tx_byte = 8'h00;
   logic ser, act, done;
   int checks = 0;
   int failures = 0;
   logic ser_log [0:1999];
   logic act_log [0:1999];
   logic done_log [0:1999];

   uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .i_Clock    (clk),
      .i_Rst_n    (rst_n),
      .i_Tx_DV    (dv),
      .i_Tx_Byte  (tx_byte),
      .o_Tx_Active(act),
      .o_Tx_Serial(ser),
      .o_Tx_Done  (done)
   );

   always #50 clk = ~clk;

   // expected line level c cycles after the cycle in which the start bit begins
   function automatic logic exp_ser(input logic [7:0] b, input int c);
      int n;
      n = c / CPB;
      if (n == 0) return 1'b0;
      if (n <= 8) return b[n-1];
      return 1'b1;
   endfunction

   function automatic logic exp_act(input int c);
      return c < FB;
   endfunction

   function automatic logic exp_done(input int c);
      return c == FB;
   endfunction

   task automatic record(input int n);
      for (int i = 0; i < n; i++) begin
         ser_log[i] = ser;
         act_log[i] = act;
         done_log[i] = done;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      int errs;
      rst_n = 1'b0;
      dv = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (ser !== 1'b1) begin failures++; $display("FAIL reset_serial got=%b want=1", ser); end
      checks++;
      if (act !== 1'b0) begin failures++; $display("FAIL reset_active got=%b want=0", act); end
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
      rst_n = 1'b1;
      errs = 0;
      repeat (1000) begin
         @(negedge clk);
         if (ser !== 1'b1 || act !== 1'b0 || done !== 1'b0) errs++;
      end
      checks++;
      if (errs != 0) begin failures++; $display("FAIL idle_quiet bad_cycles=%0d want=0", errs); end
   endtask

   task automatic test_early_dv;
      int errs, pulses, at;
      @(negedge clk);
      dv = 1'b1;
      tx_byte = 8'h00;
      @(negedge clk);
      tx_byte = 8'h63;
      fork
         record(L);
         begin @(negedge clk); dv = 1'b0; end
      join
      errs = 0; pulses = 0; at = -1;
      for (int c = 0; c < L; c++) begin
         if (ser_log[c] !== exp_ser(8'h00, c) || act_log[c] !== exp_act(c) ||
             done_log[c] !== exp_done(c)) errs++;
         if (done_log[c] === 1'b1) begin pulses++; at = c; end
      end
      checks++;
      if (errs != 0) begin failures++; $display("FAIL frame_00 bad_cycles=%0d want=0", errs); end
      checks++;
      if (pulses != 1 || at + 1 != 871)
         begin failures++; $display("FAIL done_00 pulses=%0d latency=%0d want 1 pulse at 871", pulses, at + 1); end
   endtask

   task automatic test_byte_stable;
      int errs, pulses;
      logic [7:0] mid;
      dv = 1'b1;
      tx_byte = 8'h63;
      @(negedge clk);
      dv = 1'b0;
      tx_byte = 8'h31;
      record(L);
      errs = 0; pulses = 0;
      for (int c = 0; c < L; c++) begin
         if (ser_log[c] !== exp_ser(8'h63, c) || act_log[c] !== exp_act(c) ||
             done_log[c] !== exp_done(c)) errs++;
         if (done_log[c] === 1'b1) pulses++;
      end
      for (int n = 0; n < 8; n++) mid[n] = ser_log[(n + 1) * CPB + CPB / 2];
      checks++;
      if (errs != 0) begin failures++; $display("FAIL frame_63 bad_cycles=%0d want=0", errs); end
      checks++;
      if (mid !== 8'h63) begin failures++; $display("FAIL centre_bits_63 got=%h want=63", mid); end
      checks++;
      if (pulses != 1) begin failures++; $display("FAIL done_63 pulses=%0d want=1", pulses); end
   endtask

   task automatic test_dv_mid_frame;
      int errs, pulses;
      dv = 1'b1;
      tx_byte = 8'hA5;
      @(negedge clk);
      dv = 1'b0;
      fork
         record(L + 100);
         begin
            repeat (3 * CPB) @(negedge clk);
            dv = 1'b1;
            tx_byte = 8'hFF;
            @(negedge clk);
            dv = 1'b0;
         end
      join
      errs = 0; pulses = 0;
      for (int c = 0; c < L + 100; c++) begin
         if (ser_log[c] !== exp_ser(8'hA5, c) || act_log[c] !== exp_act(c) ||
             done_log[c] !== exp_done(c)) errs++;
         if (done_log[c] === 1'b1) pulses++;
      end
      checks++;
      if (errs != 0) begin failures++; $display("FAIL frame_a5_mid_dv bad_cycles=%0d want=0", errs); end
      checks++;
      if (pulses != 1) begin failures++; $display("FAIL mid_dv_done pulses=%0d want=1", pulses); end
   endtask

   task automatic test_back_to_back;
      int errs, pulses;
      logic exp;
      dv = 1'b1;
      tx_byte = 8'h3C;
      @(negedge clk);
      dv = 1'b0;
      fork
         record(2 * L);
         begin
            repeat (L - 1) @(negedge clk);
            dv = 1'b1;
            tx_byte = 8'h96;
            @(negedge clk);
            dv = 1'b0;
         end
      join
      errs = 0; pulses = 0;
      for (int c = 0; c < 2 * L; c++) begin
         exp = (c < L) ? exp_ser(8'h3C, c) : exp_ser(8'h96, c - L);
         if (ser_log[c] !== exp) errs++;
         if (act_log[c] !== ((c < L) ? exp_act(c) : exp_act(c - L))) errs++;
         if (done_log[c] === 1'b1) pulses++;
      end
      checks++;
      if (errs != 0) begin failures++; $display("FAIL b2b_frames bad_cycles=%0d want=0", errs); end
      checks++;
      if (ser_log[FB] !== 1'b1 || ser_log[FB + 1] !== 1'b1 || ser_log[FB + 2] !== 1'b0)
         begin failures++; $display("FAIL b2b_gap got=%b%b%b want=110", ser_log[FB], ser_log[FB + 1], ser_log[FB + 2]); end
      checks++;
      if (done_log[FB] !== 1'b1 || done_log[L + FB] !== 1'b1)
         begin failures++; $display("FAIL b2b_done_pos got=%b%b want=11", done_log[FB], done_log[L + FB]); end
      checks++;
      if (pulses != 2) begin failures++; $display("FAIL b2b_done_count pulses=%0d want=2", pulses); end
   endtask

   task automatic test_reset_mid_frame;
      int errs;
      dv = 1'b1;
      tx_byte = 8'hA5;
      @(negedge clk);
      dv = 1'b0;
      repeat (5 * CPB + 40) @(negedge clk);
      checks++;
      if (ser !== 1'b0) begin failures++; $display("FAIL bit4_level got=%b want=0", ser); end
      #10;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ser !== 1'b1) begin failures++; $display("FAIL abort_serial got=%b want=1", ser); end
      checks++;
      if (act !== 1'b0) begin failures++; $display("FAIL abort_active got=%b want=0", act); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      errs = 0;
      repeat (1000) begin
         @(negedge clk);
         if (done !== 1'b0 || ser !== 1'b1 || act !== 1'b0) errs++;
      end
      checks++;
      if (errs != 0) begin failures++; $display("FAIL abort_quiet bad_cycles=%0d want=0", errs); end
   endtask

   initial begin
      test_reset;
      test_early_dv;
      test_byte_stable;
      test_dv_mid_frame;
      test_back_to_back;
      test_reset_mid_frame;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
